zx_pixel_gen: RTL and testbench



---
 rtl/zx_pixel_gen.sv | 131 +++++++++++++
 tb/tb_zx_pixel_gen.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/zx_pixel_gen.sv
`default_nettype none
// ============================================================================
// zx_pixel_gen : serialises ZX bitmap/attribute bytes into 3:3:2 pixels with
//                border, blanking, FLASH and optional ULAplus palette lookup.
// Revision     : 1.0
// ============================================================================
module zx_pixel_gen #(
  parameter int         FLASH_BIT = 4,
  parameter logic [7:0] PAL_RESET = 8'h00
) (
  input  logic       clk28,
  input  logic       rst_n,
  input  logic       ck7,
  input  logic       load,
  input  logic [7:0] bitmap_i,
  input  logic [7:0] attr_i,
  input  logic [2:0] border_i,
  input  logic       active_i,
  input  logic       blank_i,
  input  logic       frame_i,
  input  logic       up_en,
  input  logic       pal_we,
  input  logic [5:0] pal_addr,
  input  logic [7:0] pal_data,
  output logic [2:0] r_o,
  output logic [2:0] g_o,
  output logic [1:0] b_o
);

  logic [7:0] shift_q;
  logic [7:0] attr_q;
  logic       active_q;
  logic [2:0] border_q;
  logic       blank_q;
  logic       ck7_q;
  logic [4:0] flash_cnt_q;
  logic [7:0] pal_q [64];
  logic [7:0] rgb_q;

  logic       phase;
  logic       pix;
  logic [2:0] colour;
  logic       bright;
  logic [5:0] pal_idx;
  logic [7:0] pal_rd;
  logic [7:0] rgb_d;

  // Stage 1: shifter and per-pixel border/blank capture on the pixel enable
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      shift_q  <= 8'h00;
      attr_q   <= 8'h00;
      active_q <= 1'b0;
      border_q <= 3'b000;
      blank_q  <= 1'b1;
    end else if (ck7) begin
      border_q <= border_i;
      blank_q  <= blank_i;
      if (load) begin
        shift_q  <= bitmap_i;
        attr_q   <= attr_i;
        active_q <= active_i;
      end else begin
        shift_q  <= {shift_q[6:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      ck7_q       <= 1'b0;
      flash_cnt_q <= 5'd0;
    end else begin
      ck7_q <= ck7;
      if (frame_i) begin
        flash_cnt_q <= flash_cnt_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 64; k++) begin
        pal_q[k] <= PAL_RESET;
      end
    end else if (pal_we) begin
      pal_q[pal_addr] <= pal_data;
    end
  end

  assign phase = flash_cnt_q[FLASH_BIT];

  // Stage 2 colour selection; a same-edge palette write is seen only next pixel
  always_comb begin
    pix     = shift_q[7] ^ (attr_q[7] & phase & ~up_en);
    colour  = border_q;
    bright  = 1'b0;
    pal_idx = {3'b001, border_q};
    if (active_q) begin
      colour  = pix ? attr_q[2:0] : attr_q[5:3];
      bright  = attr_q[6];
      pal_idx = {attr_q[7:6], ~pix, colour};
    end
    pal_rd = pal_q[pal_idx];

    rgb_d = 8'h00;
    if (blank_q) begin
      rgb_d = 8'h00;
    end else if (up_en) begin
      rgb_d = pal_rd;
    end else begin
      rgb_d[7:5] = colour[2] ? (bright ? 3'b111 : 3'b101) : 3'b000;
      rgb_d[4:2] = colour[1] ? (bright ? 3'b111 : 3'b101) : 3'b000;
      rgb_d[1:0] = colour[0] ? (bright ? 2'b11  : 2'b10)  : 2'b00;
    end
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q <= 8'h00;
    end else if (ck7_q) begin
      rgb_q <= rgb_d;
    end
  end

  assign g_o = rgb_q[7:5];
  assign r_o = rgb_q[4:2];
  assign b_o = rgb_q[1:0];

endmodule
`default_nettype wire

// File: tb/tb_zx_pixel_gen.sv
`default_nettype none
// ============================================================================
// tb_zx_pixel_gen : directed self-checking bench for zx_pixel_gen.
// Revision        : 1.0
// ============================================================================
module tb_zx_pixel_gen;

  logic       clk28;
  logic       rst_n;
  logic       ck7;
  logic       load;
  logic [7:0] bitmap_i;
  logic [7:0] attr_i;
  logic [2:0] border_i;
  logic       active_i;
  logic       blank_i;
  logic       frame_i;
  logic       up_en;
  logic       pal_we;
  logic [5:0] pal_addr;
  logic [7:0] pal_data;
  logic [2:0] r_o;
  logic [2:0] g_o;
  logic [1:0] b_o;

  int errors = 0;
  int checks = 0;

  zx_pixel_gen #(
    .FLASH_BIT (4),
    .PAL_RESET (8'h6D)
  ) dut (
    .clk28    (clk28),
    .rst_n    (rst_n),
    .ck7      (ck7),
    .load     (load),
    .bitmap_i (bitmap_i),
    .attr_i   (attr_i),
    .border_i (border_i),
    .active_i (active_i),
    .blank_i  (blank_i),
    .frame_i  (frame_i),
    .up_en    (up_en),
    .pal_we   (pal_we),
    .pal_addr (pal_addr),
    .pal_data (pal_data),
    .r_o      (r_o),
    .g_o      (g_o),
    .b_o      (b_o)
  );

  initial clk28 = 1'b0;
  always #5 clk28 = ~clk28;

  // Expected values are packed {g[2:0], r[2:0], b[1:0]}
  task automatic chk(input string tag, input logic [7:0] exp);
    checks++;
    assert ({g_o, r_o, b_o} === exp)
    else begin
      errors++;
      $error("FAIL %s: got g=%0d r=%0d b=%0d, expected g=%0d r=%0d b=%0d",
             tag, g_o, r_o, b_o, exp[7:5], exp[4:2], exp[1:0]);
    end
  endtask

  task automatic cyc(input logic c7, input logic ld);
    ck7  = c7;
    load = ld;
    @(negedge clk28);
  endtask

  task automatic pixel(input logic ld, input string tag, input logic [7:0] exp);
    cyc(1'b1, ld);
    cyc(1'b0, 1'b0);
    chk(tag, exp);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
  endtask

  task automatic run_group(input string tag, input logic [7:0] bm,
                           input logic [7:0] on_v, input logic [7:0] off_v);
    bitmap_i = bm;
    for (int i = 0; i < 8; i++) begin
      pixel(i == 0, tag, bm[7-i] ? on_v : off_v);
    end
  endtask

  task automatic pal_write(input logic [5:0] a, input logic [7:0] d);
    pal_we   = 1'b1;
    pal_addr = a;
    pal_data = d;
    cyc(1'b0, 1'b0);
    pal_we   = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_i = 1'b1;
      cyc(1'b0, 1'b0);
      frame_i = 1'b0;
      cyc(1'b0, 1'b0);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    ck7      = 1'b0;
    load     = 1'b0;
    bitmap_i = 8'h00;
    attr_i   = 8'h00;
    border_i = 3'b000;
    active_i = 1'b0;
    blank_i  = 1'b0;
    frame_i  = 1'b0;
    up_en    = 1'b0;
    pal_we   = 1'b0;
    pal_addr = 6'd0;
    pal_data = 8'h00;
    repeat (3) @(negedge clk28);
    chk("reset_state", 8'h00);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0);

    // Normal mode, bright white ink on black paper
    active_i = 1'b1;
    attr_i   = 8'h47;
    run_group("norm_bright", 8'hA5, 8'hFF, 8'h00);

    // Non-bright ink: {5,5,2}
    attr_i = 8'h07;
    run_group("norm_dim", 8'hA5, 8'hB6, 8'h00);

    // FLASH: phase bit is flash_cnt[4]
    attr_i = 8'hC7;
    run_group("flash_ph0", 8'hA5, 8'hFF, 8'h00);
    frames(16);
    run_group("flash_inv", 8'hA5, 8'h00, 8'hFF);
    frames(16);
    run_group("flash_wrap", 8'hA5, 8'hFF, 8'h00);

    // Border with per-pixel granularity
    active_i = 1'b0;
    border_i = 3'b010;
    pixel(1'b1, "border_red", 8'h14);
    border_i = 3'b001;
    pixel(1'b0, "border_blue", 8'h02);
    border_i = 3'b110;
    pixel(1'b0, "border_yel", 8'hB4);

    // ULAplus: ink 7 -> index 0x07, paper 7 -> index 0x0F, border 2 -> 0x0A
    up_en = 1'b1;
    pal_write(6'h07, 8'hE3);
    pal_write(6'h0F, 8'h1C);
    pal_write(6'h0A, 8'h41);
    border_i = 3'b010;
    pixel(1'b1, "ulap_border", 8'h41);
    active_i = 1'b1;
    attr_i   = 8'h07;
    bitmap_i = 8'hFF;
    pixel(1'b1, "ulap_ink0", 8'hE3);
    pixel(1'b0, "ulap_ink1", 8'hE3);
    attr_i   = 8'h38;
    bitmap_i = 8'h00;
    pixel(1'b1, "ulap_paper", 8'h1C);

    // ULAplus ignores FLASH: attr C7 uses CLUT 3, ink -> index 0x37
    pal_write(6'h37, 8'h92);
    frames(16);
    attr_i   = 8'hC7;
    bitmap_i = 8'hFF;
    pixel(1'b1, "ulap_noflash", 8'h92);
    frames(16);

    // Write coinciding with the stage-2 read of the same index
    attr_i   = 8'h07;
    bitmap_i = 8'hFF;
    cyc(1'b1, 1'b1);
    pal_we   = 1'b1;
    pal_addr = 6'h07;
    pal_data = 8'h1C;
    cyc(1'b0, 1'b0);
    pal_we   = 1'b0;
    chk("pal_same_edge_old", 8'hE3);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    pixel(1'b0, "pal_next_new", 8'h1C);

    // up_en switched mid-group takes effect on the next pixel
    up_en = 1'b0;
    pixel(1'b0, "upen_off_mid", 8'hB6);

    // Blanking forces zero
    attr_i  = 8'h47;
    blank_i = 1'b1;
    pixel(1'b1, "blank0", 8'h00);
    pixel(1'b0, "blank1", 8'h00);
    blank_i = 1'b0;
    pixel(1'b0, "unblank", 8'hFF);

    // Load without ck7 is ignored: shifter keeps 0xFF pattern
    bitmap_i = 8'h00;
    cyc(1'b0, 1'b1);
    pixel(1'b0, "load_no_ck7", 8'hFF);

    // Asynchronous reset mid-group, palette back to PAL_RESET
    bitmap_i = 8'hFF;
    pixel(1'b1, "pre_reset", 8'hFF);
    cyc(1'b1, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("reset_async", 8'h00);
    cyc(1'b0, 1'b0);
    rst_n    = 1'b1;
    up_en    = 1'b1;
    attr_i   = 8'h07;
    cyc(1'b0, 1'b0);
    chk("post_reset_zero", 8'h00);
    pixel(1'b1, "pal_reset_val", 8'h6D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
